// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads and rbusy are combinational with zero-cycle latency. Writes and busy bits update on the rising edge.
// No backpressure: every write, read and issue is accepted in the cycle it is presented.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rbusy1,
  output logic            rbusy2,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Address matches between each read port and each write port.
  logic hit1_w0, hit1_w1, hit2_w0, hit2_w1;
  assign hit1_w0 = we0 && (waddr0 == raddr1);
  assign hit1_w1 = we1 && (waddr1 == raddr1);
  assign hit2_w0 = we0 && (waddr0 == raddr2);
  assign hit2_w1 = we1 && (waddr1 == raddr2);

  // Register storage: port 1 overrides port 0 when both target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (!(ZERO_REG && r == 0)) begin
          if (we1 && waddr1 == AW'(r))      regs[r] <= wdata1;
          else if (we0 && waddr0 == AW'(r)) regs[r] <= wdata0;
        end
      end
    end
  end

  // Read port 1: stored value, optionally forwarded from a same-cycle write; reg 0 forced to zero.
  always_comb begin
    rdata1 = regs[raddr1];
    if (BYPASS) begin
      if (hit1_w1)      rdata1 = wdata1;
      else if (hit1_w0) rdata1 = wdata0;
    end
    if (ZERO_REG && raddr1 == '0) rdata1 = '0;
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rdata2 = regs[raddr2];
    if (BYPASS) begin
      if (hit2_w1)      rdata2 = wdata1;
      else if (hit2_w0) rdata2 = wdata0;
    end
    if (ZERO_REG && raddr2 == '0) rdata2 = '0;
  end

  // Busy flags seen by the reader: a same-cycle writeback already satisfies the dependency when bypassing.
  always_comb begin
    rbusy1 = busy_q[raddr1] && !(BYPASS && (hit1_w0 || hit1_w1));
    rbusy2 = busy_q[raddr2] && !(BYPASS && (hit2_w0 || hit2_w1));
  end

  // Scoreboard next state: an issue sets busy and beats a same-cycle writeback clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (iss_valid && iss_rd == AW'(r))
        busy_d[r] = 1'b1;
      else if ((we0 && waddr0 == AW'(r)) || (we1 && waddr1 == AW'(r)))
        busy_d[r] = 1'b0;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters: 32x32, ZERO_REG = 1, BYPASS = 1).
// Expected values are queued with the cycle they fall due and compared at mid-cycle.
// Directed cases first, then a randomised phase against a behavioural model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   raddr1, raddr2, waddr0, waddr1, iss_rd;
  logic [XLEN-1:0] rdata1, rdata2, wdata0, wdata1;
  logic            rbusy1, rbusy2, we0, we1, iss_valid;
  logic [NREGS-1:0] busy_vec;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  typedef struct {
    int          due;
    int          sel;   // 0 rdata1, 1 rdata2, 2 rbusy1, 3 rbusy2, 4 busy_vec
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   cycle  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [XLEN-1:0]  m_reg [NREGS];
  logic [NREGS-1:0] m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       return rdata1;
      1:       return rdata2;
      2:       return {31'b0, rbusy1};
      3:       return {31'b0, rbusy2};
      default: return busy_vec;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e, input int dly);
    exp_t x;
    x.due = cycle + dly;
    x.sel = sel;
    x.exp = e;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic check_due();
    exp_t keep[$];
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cycle) chk(exp_q[i].tag, obs(exp_q[i].sel), exp_q[i].exp);
      else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    #1;
    check_due();
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    iss_valid = 1'b0; iss_rd = '0;
    raddr1 = '0; raddr2 = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    logic [31:0] v;
    v = m_reg[a];
    if (we1 && waddr1 == a)      v = wdata1;
    else if (we0 && waddr0 == a) v = wdata0;
    if (a == '0) v = '0;
    return v;
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    return m_busy[a] && !((we0 && waddr0 == a) || (we1 && waddr1 == a));
  endfunction

  task automatic m_step();
    logic [NREGS-1:0] nb;
    nb = m_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (iss_valid && iss_rd == AW'(r)) nb[r] = 1'b1;
      else if ((we0 && waddr0 == AW'(r)) || (we1 && waddr1 == AW'(r))) nb[r] = 1'b0;
    end
    nb[0] = 1'b0;
    if (we0 && waddr0 != '0) m_reg[waddr0] = wdata0;
    if (we1 && waddr1 != '0) m_reg[waddr1] = wdata1;
    m_busy = nb;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);

    // Reset held: every address reads zero, nothing busy.
    for (int i = 0; i < NREGS; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(NREGS - 1 - i);
      push("rst_rdata1", 0, 32'h0, 0);
      push("rst_rdata2", 1, 32'h0, 0);
      push("rst_busy", 4, 32'h0, 0);
      cyc();
    end
    rst_n = 1'b1;

    // Reset asserted across a write and an issue: both discarded.
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA5A5A5A5;
    iss_valid = 1'b1; iss_rd = 5'd10;
    rst_n = 1'b0;
    cyc();
    idle(); rst_n = 1'b1; raddr1 = 5'd10;
    push("midrst_rdata", 0, 32'h0, 0);
    push("midrst_busy", 4, 32'h0, 0);
    cyc();

    // Forwarding of a port 0 write, then the stored value.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr1 = 5'd5;
    push("byp_w0", 0, 32'hDEADBEEF, 0);
    cyc();
    idle(); raddr1 = 5'd5;
    push("stored_w0", 0, 32'hDEADBEEF, 0);
    cyc();

    // Both ports to the same register: port 1 wins, forwarded and stored.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    raddr1 = 5'd7; raddr2 = 5'd7;
    push("prio_byp1", 0, 32'h22, 0);
    push("prio_byp2", 1, 32'h22, 0);
    cyc();
    idle(); raddr1 = 5'd7;
    push("prio_stored", 0, 32'h22, 0);
    cyc();

    // Register 0: write and issue are both ignored.
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; raddr1 = 5'd0;
    push("r0_byp", 0, 32'h0, 0);
    push("r0_rbusy", 2, 32'h0, 0);
    cyc();
    idle(); raddr1 = 5'd0;
    push("r0_stored", 0, 32'h0, 0);
    push("r0_busy", 4, 32'h0, 0);
    cyc();

    // Issue to r3, then a writeback clears it.
    iss_valid = 1'b1; iss_rd = 5'd3;
    push("iss3_pre", 4, 32'h0, 0);
    cyc();
    idle(); raddr1 = 5'd3;
    push("iss3_busy", 4, 32'h8, 0);
    push("iss3_rbusy", 2, 32'h1, 0);
    cyc();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33; raddr1 = 5'd3;
    push("wb3_rbusy", 2, 32'h0, 0);
    push("wb3_rdata", 0, 32'h33, 0);
    push("wb3_busy_now", 4, 32'h8, 0);
    cyc();
    idle(); raddr1 = 5'd3;
    push("wb3_busy", 4, 32'h0, 0);
    push("wb3_rbusy_after", 2, 32'h0, 0);
    cyc();

    // Issue and writeback to r9 in one cycle: set wins, data stored.
    iss_valid = 1'b1; iss_rd = 5'd9;
    cyc();
    iss_valid = 1'b1; iss_rd = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99; raddr2 = 5'd9;
    push("set_clr_busy_now", 4, 32'h200, 0);
    push("set_clr_rbusy2", 3, 32'h0, 0);
    push("set_clr_rdata2", 1, 32'h99, 0);
    cyc();
    idle(); raddr2 = 5'd9;
    push("set_clr_busy", 4, 32'h200, 0);
    push("set_clr_rbusy2_after", 3, 32'h1, 0);
    push("set_clr_stored", 1, 32'h99, 0);
    cyc();

    // Clear r4 while setting r6.
    iss_valid = 1'b1; iss_rd = 5'd4;
    cyc();
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    iss_valid = 1'b1; iss_rd = 5'd6;
    push("mix_busy_now", 4, 32'h210, 0);
    cyc();
    idle();
    push("mix_busy", 4, 32'h240, 0);
    cyc();

    // Asynchronous reset: state clears without a clock edge.
    iss_valid = 1'b1; iss_rd = 5'd12;
    cyc();
    idle(); raddr1 = 5'd5; raddr2 = 5'd7;
    push("pre_arst_rdata1", 0, 32'hDEADBEEF, 0);
    push("pre_arst_busy", 4, 32'h1240, 0);
    cyc();
    rst_n = 1'b0;
    push("arst_rdata1", 0, 32'h0, 0);
    push("arst_rdata2", 1, 32'h0, 0);
    push("arst_busy", 4, 32'h0, 0);
    cyc();
    rst_n = 1'b1;
    idle();

    // Randomised traffic against the model, starting from the reset state.
    for (int r = 0; r < NREGS; r++) m_reg[r] = '0;
    m_busy = '0;
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = rnd_addr(); wdata0 = $urandom();
      we1 = 1'($urandom_range(0, 1)); waddr1 = rnd_addr(); wdata1 = $urandom();
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = rnd_addr();
      raddr1 = rnd_addr(); raddr2 = rnd_addr();
      push("rnd_rdata1", 0, m_read(raddr1), 0);
      push("rnd_rdata2", 1, m_read(raddr2), 0);
      push("rnd_rbusy1", 2, {31'b0, m_rbusy(raddr1)}, 0);
      push("rnd_rbusy2", 3, {31'b0, m_rbusy(raddr2)}, 0);
      push("rnd_busy", 4, m_busy, 0);
      cyc();
      m_step();
    end

    idle();
    cyc();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
